uart_rx_match: RTL and testbench

UART_RX_MATCH -- requirements
Module: uart_rx_match

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 26 ++
 rtl/uart_rx_match.sv | 143 ++++++++++++++
 tb/tb_uart_rx_match.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receiver: FSM state encoding and parity mode selectors.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } rx_state_e;

    localparam int unsigned ParityNone = 0;
    localparam int unsigned ParityEven = 1;
    localparam int unsigned ParityOdd  = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_match.sv
// UART receiver with optional parity; drives LEDs showing whether the last good word
// equals MATCH_VALUE.
module uart_rx_match
    import uart_pkg::*;
#(
    parameter int unsigned          CLKS_PER_BIT = 434,
    parameter int unsigned          DATA_BITS    = 8,
    parameter int unsigned          PARITY_MODE  = ParityNone,
    parameter logic [DATA_BITS-1:0] MATCH_VALUE  = DATA_BITS'('h61)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx_serial,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_led_match,
    output logic                 o_led_nomatch
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW = 4;

    localparam logic [CntW-1:0] CntMax  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);
    localparam logic            OddPar  = (PARITY_MODE == ParityOdd);

    logic                 rx_sync;
    rx_state_e            state_q;
    logic [CntW-1:0]      cnt_q;
    logic [BitW-1:0]      bit_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 par_bad_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 match_q;

    sync_2ff #(
        .ResetVal(1'b1)
    ) u_sync (
        .clk_i (i_clk),
        .rst_ni(i_rst_n),
        .d_i   (i_rx_serial),
        .q_o   (rx_sync)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            par_bad_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (!rx_sync) begin
                        bit_q     <= '0;
                        par_bad_q <= 1'b0;
                        state_q   <= StStart;
                    end
                end
                StStart: begin
                    // Mid-bit recheck rejects short glitches before committing to a frame.
                    if (cnt_q == CntHalf) begin
                        cnt_q   <= '0;
                        state_q <= rx_sync ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (cnt_q == CntMax) begin
                        cnt_q   <= '0;
                        shreg_q <= {rx_sync, shreg_q[DATA_BITS-1:1]};
                        bit_q   <= bit_q + BitW'(1);
                        if (bit_q == LastBit) begin
                            state_q <= (PARITY_MODE != ParityNone) ? StParity : StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StParity: begin
                    if (cnt_q == CntMax) begin
                        cnt_q     <= '0;
                        par_bad_q <= ((^shreg_q) ^ rx_sync) != OddPar;
                        state_q   <= StStop;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StStop: begin
                    if (cnt_q == CntMax) begin
                        cnt_q <= '0;
                        if (!rx_sync) begin
                            ferr_q  <= 1'b1;
                            state_q <= StWaitIdle;
                        end else if (par_bad_q) begin
                            perr_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            valid_q <= 1'b1;
                            data_q  <= shreg_q;
                            match_q <= (shreg_q == MATCH_VALUE);
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWaitIdle: begin
                    // A held-low line (break) must not be mistaken for a new start bit.
                    if (rx_sync) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_rx_data     = data_q;
    assign o_rx_valid    = valid_q;
    assign o_parity_err  = perr_q;
    assign o_frame_err   = ferr_q;
    assign o_led_match   = match_q;
    assign o_led_nomatch = ~match_q;

endmodule

// File: tb/tb_uart_rx_match.sv
// Directed bench for uart_rx_match: an 8N1 instance and an even-parity instance, CLKS_PER_BIT = 8.
module tb_uart_rx_match;

    localparam int unsigned Clks = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rx_p;

    logic [7:0] data;
    logic       valid, perr, ferr, match, nomatch;
    logic [7:0] p_data;
    logic       p_valid, p_perr, p_ferr, p_match, p_nomatch;

    int n_valid = 0, n_perr = 0, n_ferr = 0;
    int p_n_valid = 0, p_n_perr = 0, p_n_ferr = 0;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_rx_match #(
        .CLKS_PER_BIT(Clks),
        .DATA_BITS   (8),
        .PARITY_MODE (0),
        .MATCH_VALUE (8'h61)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_serial  (rx),
        .o_rx_data    (data),
        .o_rx_valid   (valid),
        .o_parity_err (perr),
        .o_frame_err  (ferr),
        .o_led_match  (match),
        .o_led_nomatch(nomatch)
    );

    uart_rx_match #(
        .CLKS_PER_BIT(Clks),
        .DATA_BITS   (8),
        .PARITY_MODE (1),
        .MATCH_VALUE (8'h61)
    ) dut_p (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_serial  (rx_p),
        .o_rx_data    (p_data),
        .o_rx_valid   (p_valid),
        .o_parity_err (p_perr),
        .o_frame_err  (p_ferr),
        .o_led_match  (p_match),
        .o_led_nomatch(p_nomatch)
    );

    // Pulse counters, sampled on the falling edge away from DUT updates.
    always @(negedge clk) begin
        if (valid)   n_valid   <= n_valid + 1;
        if (perr)    n_perr    <= n_perr + 1;
        if (ferr)    n_ferr    <= n_ferr + 1;
        if (p_valid) p_n_valid <= p_n_valid + 1;
        if (p_perr)  p_n_perr  <= p_n_perr + 1;
        if (p_ferr)  p_n_ferr  <= p_n_ferr + 1;
    end

    task automatic drive_bit(input logic on_p, input logic b);
        @(negedge clk);
        if (on_p) rx_p = b;
        else      rx = b;
        repeat (Clks - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic on_p, input logic [7:0] d, input logic has_par,
                              input logic par_bit, input logic stop_bit);
        drive_bit(on_p, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(on_p, d[i]);
        if (has_par) drive_bit(on_p, par_bit);
        drive_bit(on_p, stop_bit);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rx    = 1'b1;
        rx_p  = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (data !== 8'h00) begin
            fails++; $display("FAIL reset_data: got %0h expected 00", data);
        end
        checks++;
        if ({valid, perr, ferr} !== 3'b000) begin
            fails++; $display("FAIL reset_pulses: got %b expected 000", {valid, perr, ferr});
        end
        checks++;
        if (match !== 1'b0) begin
            fails++; $display("FAIL reset_match: got %b expected 0", match);
        end
        checks++;
        if (nomatch !== 1'b1) begin
            fails++; $display("FAIL reset_nomatch: got %b expected 1", nomatch);
        end
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic test_match();
        int v0, p0, f0;
        @(posedge clk);
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_frame(1'b0, 8'h61, 1'b0, 1'b0, 1'b1);
        idle(4);
        @(posedge clk);
        checks++;
        if (n_valid - v0 !== 1) begin
            fails++; $display("FAIL match_valid_count: got %0d expected 1", n_valid - v0);
        end
        checks++;
        if (data !== 8'h61) begin
            fails++; $display("FAIL match_data: got %0h expected 61", data);
        end
        checks++;
        if ({match, nomatch} !== 2'b10) begin
            fails++; $display("FAIL match_leds: got %b expected 10", {match, nomatch});
        end
        checks++;
        if ((n_perr - p0) + (n_ferr - f0) !== 0) begin
            fails++; $display("FAIL match_err_pulses: got %0d expected 0",
                              (n_perr - p0) + (n_ferr - f0));
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        @(posedge clk);
        v0 = n_valid;
        send_frame(1'b0, 8'h61, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h62, 1'b0, 1'b0, 1'b1);
        idle(4);
        @(posedge clk);
        checks++;
        if (n_valid - v0 !== 2) begin
            fails++; $display("FAIL b2b_valid_count: got %0d expected 2", n_valid - v0);
        end
        checks++;
        if (data !== 8'h62) begin
            fails++; $display("FAIL b2b_data: got %0h expected 62", data);
        end
        checks++;
        if ({match, nomatch} !== 2'b01) begin
            fails++; $display("FAIL b2b_leds: got %b expected 01", {match, nomatch});
        end
    endtask

    task automatic test_parity();
        int v0, p0, f0;
        @(posedge clk);
        v0 = p_n_valid;
        // 0x5A has four ones, so the even parity bit is 0.
        send_frame(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
        idle(4);
        @(posedge clk);
        checks++;
        if (p_n_valid - v0 !== 1 || p_data !== 8'h5A) begin
            fails++; $display("FAIL parity_good: got count %0d data %0h expected 1 5a",
                              p_n_valid - v0, p_data);
        end
        v0 = p_n_valid; p0 = p_n_perr; f0 = p_n_ferr;
        send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
        idle(4);
        @(posedge clk);
        checks++;
        if (p_n_perr - p0 !== 1) begin
            fails++; $display("FAIL parity_err_count: got %0d expected 1", p_n_perr - p0);
        end
        checks++;
        if (p_n_valid - v0 !== 0) begin
            fails++; $display("FAIL parity_valid_count: got %0d expected 0", p_n_valid - v0);
        end
        checks++;
        if (p_data !== 8'h5A) begin
            fails++; $display("FAIL parity_data_kept: got %0h expected 5a", p_data);
        end
        checks++;
        if (p_n_ferr - f0 !== 0) begin
            fails++; $display("FAIL parity_ferr_count: got %0d expected 0", p_n_ferr - f0);
        end
    endtask

    task automatic test_frame_err();
        int v0, p0, f0;
        @(posedge clk);
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        idle(40);
        @(posedge clk);
        checks++;
        if (n_ferr - f0 !== 1) begin
            fails++; $display("FAIL ferr_count_low: got %0d expected 1", n_ferr - f0);
        end
        checks++;
        if ((n_valid - v0) + (n_perr - p0) !== 0) begin
            fails++; $display("FAIL ferr_other_pulses: got %0d expected 0",
                              (n_valid - v0) + (n_perr - p0));
        end
        @(negedge clk);
        rx = 1'b1;
        idle(20);
        @(posedge clk);
        checks++;
        if (n_ferr - f0 !== 1 || n_valid - v0 !== 0) begin
            fails++; $display("FAIL ferr_after_release: got ferr %0d valid %0d expected 1 0",
                              n_ferr - f0, n_valid - v0);
        end
        checks++;
        if (data !== 8'h62) begin
            fails++; $display("FAIL ferr_data_kept: got %0h expected 62", data);
        end
        v0 = n_valid;
        send_frame(1'b0, 8'h61, 1'b0, 1'b0, 1'b1);
        idle(4);
        @(posedge clk);
        checks++;
        if (n_valid - v0 !== 1 || data !== 8'h61) begin
            fails++; $display("FAIL ferr_recover: got count %0d data %0h expected 1 61",
                              n_valid - v0, data);
        end
    endtask

    task automatic test_glitch();
        int v0, p0, f0;
        @(posedge clk);
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        @(negedge clk);
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(30);
        @(posedge clk);
        checks++;
        if ((n_valid - v0) + (n_perr - p0) + (n_ferr - f0) !== 0) begin
            fails++; $display("FAIL glitch_pulses: got %0d expected 0",
                              (n_valid - v0) + (n_perr - p0) + (n_ferr - f0));
        end
        v0 = n_valid;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        idle(4);
        @(posedge clk);
        checks++;
        if (n_valid - v0 !== 1 || data !== 8'h55) begin
            fails++; $display("FAIL glitch_recover: got count %0d data %0h expected 1 55",
                              n_valid - v0, data);
        end
        checks++;
        if ({match, nomatch} !== 2'b01) begin
            fails++; $display("FAIL glitch_leds: got %b expected 01", {match, nomatch});
        end
    endtask

    task automatic test_reset_midframe();
        int v0, p0, f0;
        @(posedge clk);
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        // Frame 0xF0: reset lands in bit 4 while the line is high.
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0);
        @(negedge clk);
        rx = 1'b1;
        idle(2);
        rst_n = 1'b0;
        idle(3);
        checks++;
        if (data !== 8'h00 || match !== 1'b0) begin
            fails++; $display("FAIL midreset_state: got data %0h match %b expected 00 0",
                              data, match);
        end
        rst_n = 1'b1;
        idle(40);
        @(posedge clk);
        checks++;
        if ((n_valid - v0) + (n_perr - p0) + (n_ferr - f0) !== 0) begin
            fails++; $display("FAIL midreset_partial: got %0d pulses expected 0",
                              (n_valid - v0) + (n_perr - p0) + (n_ferr - f0));
        end
        send_frame(1'b0, 8'h61, 1'b0, 1'b0, 1'b1);
        idle(4);
        @(posedge clk);
        checks++;
        if (n_valid - v0 !== 1 || data !== 8'h61 || match !== 1'b1) begin
            fails++; $display("FAIL midreset_frame: got count %0d data %0h match %b expected 1 61 1",
                              n_valid - v0, data, match);
        end
        checks++;
        if ((n_perr - p0) + (n_ferr - f0) !== 0) begin
            fails++; $display("FAIL midreset_errs: got %0d expected 0",
                              (n_perr - p0) + (n_ferr - f0));
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_back_to_back();
        test_parity();
        test_frame_err();
        test_glitch();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
